// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared pipeline entry type and NOP encoding for the IF/ID queue
package if_id_queue_pkg;
   localparam int IF_ID_XLEN = 32;
   localparam logic [31:0] IF_ID_NOP = 32'h0000_0013;
   typedef struct packed {
      logic [IF_ID_XLEN-1:0] pc;
      logic [IF_ID_XLEN-1:0] instr;
      logic                  compress;
   } if_id_entry_t;
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH x W register array, one write port, one async read port
module if_id_queue_mem #(
   parameter int DEPTH = 2,
   parameter int W = 65,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);
   logic [W-1:0] mem [DEPTH];
   // storage is never reset; occupancy alone decides which entries are live
   always_ff @(posedge i_clk)
      if (i_we) mem[i_waddr] <= i_wdata;
   assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID decoupling FIFO with flush; IF_ID_FLUSH_NOP_EN leaves a NOP after flush
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int XLEN = IF_ID_XLEN,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instr,
   input  logic            i_compress,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_instr,
   output logic            o_compress,
   input  logic            i_flush,
   output logic [CW-1:0]   o_count
);
`ifdef IF_ID_FLUSH_NOP_EN
   localparam int FLUSH_CNT = 1;
`else
   localparam int FLUSH_CNT = 0;
`endif
   logic [AW-1:0] wptr, rptr, waddr;
   logic [CW-1:0] count;
   logic wr, rd, we;
   if_id_entry_t in_e, rd_e, wdata;
   assign wr = i_valid & o_ready;
   assign rd = o_valid & i_ready;
   assign in_e = '{pc: IF_ID_XLEN'(i_pc), instr: IF_ID_XLEN'(i_instr), compress: i_compress};
`ifdef IF_ID_FLUSH_NOP_EN
   if_id_entry_t nop_e;
   assign nop_e = '{pc: IF_ID_XLEN'(i_pc), instr: IF_ID_XLEN'(IF_ID_NOP), compress: 1'b0};
   assign we = ~i_reset & (i_flush | wr);
   assign waddr = i_flush ? '0 : wptr;
   assign wdata = i_flush ? nop_e : in_e;
`else
   assign we = ~i_reset & ~i_flush & wr;
   assign waddr = wptr;
   assign wdata = in_e;
`endif
   if_id_queue_mem #(.DEPTH(DEPTH), .W($bits(if_id_entry_t))) u_mem (
      .i_clk   (i_clk),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_raddr (rptr),
      .o_rdata (rd_e)
   );
   // pointers and occupancy; reset beats flush, flush beats both handshakes
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (i_flush) begin
         wptr  <= AW'(FLUSH_CNT);
         rptr  <= '0;
         count <= CW'(FLUSH_CNT);
      end else begin
         wptr  <= wptr + AW'(wr);
         rptr  <= rptr + AW'(rd);
         count <= count + CW'(wr) - CW'(rd);
      end
   end
   assign o_count = count;
   assign o_valid = count != '0;
   assign o_ready = count != CW'(DEPTH);
   assign o_pc = o_valid ? XLEN'(rd_e.pc) : '0;
   assign o_instr = o_valid ? XLEN'(rd_e.instr) : '0;
   assign o_compress = o_valid & rd_e.compress;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue (DEPTH=2 and DEPTH=4 instances)
module tb_if_id_queue;
   logic clk = 0, rst = 1;
   logic v = 0, ordy, rdy = 0, cmp = 0, flush = 0, ov, ocmp;
   logic [31:0] pc = 0, instr = 0, opc, oinstr;
   logic [1:0] cnt;
   logic v4 = 0, ordy4, rdy4 = 0, cmp4 = 0, ov4, ocmp4;
   logic [31:0] pc4 = 0, instr4 = 0, opc4, oinstr4;
   logic [2:0] cnt4;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   if_id_queue #(.XLEN(32), .DEPTH(2)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_valid(v), .o_ready(ordy), .i_pc(pc), .i_instr(instr),
      .i_compress(cmp), .o_valid(ov), .i_ready(rdy), .o_pc(opc), .o_instr(oinstr),
      .o_compress(ocmp), .i_flush(flush), .o_count(cnt)
   );

   if_id_queue #(.XLEN(32), .DEPTH(4)) u_dut4 (
      .i_clk(clk), .i_reset(rst), .i_valid(v4), .o_ready(ordy4), .i_pc(pc4), .i_instr(instr4),
      .i_compress(cmp4), .o_valid(ov4), .i_ready(rdy4), .o_pc(opc4), .o_instr(oinstr4),
      .o_compress(ocmp4), .i_flush(1'b0), .o_count(cnt4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      total++; if ({ov, ordy, cnt} !== {1'b0, 1'b1, 2'd0}) begin bad++; $display("FAIL rst_init got v=%b r=%b c=%0d exp v=0 r=1 c=0", ov, ordy, cnt); end
      total++; if ({opc, oinstr, ocmp} !== 65'd0) begin bad++; $display("FAIL rst_init_payload got pc=%h in=%h c=%b exp 0", opc, oinstr, ocmp); end
      v = 1; pc = 32'h10; instr = 32'haa; tick;
      pc = 32'h14; instr = 32'hbb; tick;
      v = 0;
      total++; if (cnt !== 2'd2) begin bad++; $display("FAIL rst_prefill got=%0d exp=2", cnt); end
      rst = 1; v = 1; rdy = 1; tick; tick;
      rst = 0; v = 0; rdy = 0;
      total++; if ({ov, ordy, cnt} !== {1'b0, 1'b1, 2'd0}) begin bad++; $display("FAIL rst_mid got v=%b r=%b c=%0d exp v=0 r=1 c=0", ov, ordy, cnt); end
      total++; if ({opc, oinstr, ocmp} !== 65'd0) begin bad++; $display("FAIL rst_mid_payload got pc=%h in=%h c=%b exp 0", opc, oinstr, ocmp); end
   endtask

   task automatic test_fill_drain;
      rdy = 0; v = 1; pc = 32'h100; instr = 32'h1000; cmp = 1; tick;
      total++; if ({ov, cnt, opc, ocmp} !== {1'b1, 2'd1, 32'h100, 1'b1}) begin bad++; $display("FAIL fill1 got v=%b c=%0d pc=%h cm=%b exp v=1 c=1 pc=100 cm=1", ov, cnt, opc, ocmp); end
      pc = 32'h104; instr = 32'h1004; cmp = 0; tick;
      total++; if ({ordy, cnt} !== {1'b0, 2'd2}) begin bad++; $display("FAIL fill2 got r=%b c=%0d exp r=0 c=2", ordy, cnt); end
      pc = 32'h108; instr = 32'h1008; tick;
      total++; if ({cnt, opc} !== {2'd2, 32'h100}) begin bad++; $display("FAIL fill3_ignored got c=%0d pc=%h exp c=2 pc=100", cnt, opc); end
      v = 0; rdy = 1; tick;
      total++; if ({opc, oinstr, ocmp, cnt} !== {32'h104, 32'h1004, 1'b0, 2'd1}) begin bad++; $display("FAIL drain1 got pc=%h in=%h c=%0d exp pc=104 in=1004 c=1", opc, oinstr, cnt); end
      tick;
      total++; if ({ov, cnt, opc} !== {1'b0, 2'd0, 32'h0}) begin bad++; $display("FAIL drain_empty got v=%b c=%0d pc=%h exp v=0 c=0 pc=0", ov, cnt, opc); end
      rdy = 0;
   endtask

   task automatic test_streaming;
      v = 1; rdy = 1;
      for (int i = 0; i < 8; i++) begin
         pc = 32'h200 + 32'(4 * i); instr = 32'h3000 + 32'(i); tick;
         total++; if ({cnt, opc, oinstr} !== {2'd1, 32'h200 + 32'(4 * i), 32'h3000 + 32'(i)}) begin bad++; $display("FAIL stream%0d got c=%0d pc=%h in=%h exp c=1 pc=%h", i, cnt, opc, oinstr, 32'h200 + 32'(4 * i)); end
      end
      v = 0; tick;
      total++; if ({ov, cnt} !== {1'b0, 2'd0}) begin bad++; $display("FAIL stream_end got v=%b c=%0d exp v=0 c=0", ov, cnt); end
      rdy = 0;
   endtask

   task automatic test_full_read;
      v = 1; pc = 32'h300; instr = 32'h5000; tick;
      pc = 32'h304; instr = 32'h5004; tick;
      pc = 32'h308; instr = 32'h5008; rdy = 1; tick;
      v = 0;
      total++; if ({cnt, opc} !== {2'd1, 32'h304}) begin bad++; $display("FAIL full_read got c=%0d pc=%h exp c=1 pc=304", cnt, opc); end
      tick;
      total++; if ({ov, cnt} !== {1'b0, 2'd0}) begin bad++; $display("FAIL full_read_drop got v=%b c=%0d exp v=0 c=0", ov, cnt); end
      rdy = 0;
   endtask

   task automatic test_flush;
      v = 1; pc = 32'h400; instr = 32'h4000; tick;
      pc = 32'h404; instr = 32'h4444; cmp = 1; rdy = 1; flush = 1; tick;
      v = 0; rdy = 0; flush = 0; cmp = 0;
`ifdef IF_ID_FLUSH_NOP_EN
      total++; if ({ov, cnt, opc, oinstr, ocmp} !== {1'b1, 2'd1, 32'h404, 32'h13, 1'b0}) begin bad++; $display("FAIL flush_nop got v=%b c=%0d pc=%h in=%h cm=%b exp v=1 c=1 pc=404 in=13 cm=0", ov, cnt, opc, oinstr, ocmp); end
      rdy = 1; tick; rdy = 0;
`else
      total++; if ({ov, cnt, opc} !== {1'b0, 2'd0, 32'h0}) begin bad++; $display("FAIL flush got v=%b c=%0d pc=%h exp v=0 c=0 pc=0", ov, cnt, opc); end
`endif
      total++; if ({ov, ordy, cnt} !== {1'b0, 1'b1, 2'd0}) begin bad++; $display("FAIL flush_after got v=%b r=%b c=%0d exp v=0 r=1 c=0", ov, ordy, cnt); end
   endtask

   task automatic test_wrap;
      int sent = 0, recv = 0;
      for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
         rdy4 = 1'($urandom_range(0, 1));
         v4 = sent < 10;
         pc4 = 32'h500 + 32'(4 * sent); instr4 = ~pc4; cmp4 = 1'(sent);
         #1;
         if (ov4 && rdy4) begin
            total++; if ({opc4, oinstr4, ocmp4} !== {32'h500 + 32'(4 * recv), ~(32'h500 + 32'(4 * recv)), 1'(recv)}) begin bad++; $display("FAIL wrap%0d got pc=%h in=%h cm=%b exp pc=%h", recv, opc4, oinstr4, ocmp4, 32'h500 + 32'(4 * recv)); end
            recv++;
         end
         if (v4 && ordy4) sent++;
         tick;
      end
      v4 = 0; rdy4 = 0;
      total++; if (recv !== 10 || cnt4 !== 3'd0) begin bad++; $display("FAIL wrap_done got recv=%0d c=%0d exp recv=10 c=0", recv, cnt4); end
   endtask

   initial begin
      tick; tick;
      rst = 0;
      test_reset;
      test_fill_drain;
      test_streaming;
      test_full_read;
      test_flush;
      test_wrap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
